traffic_ctrl_timed: RTL

// - Parametrised two-road traffic-light controller with on-chip XNOR LFSR traffic sensors.
// - Adds min/max green timing, timed yellow, optional all-red clearance, an external-sensor mode and a hold input.
// - Drives the per-road red/yellow/green lamps at the top of the traffic sim.

---
 rtl/traffic_ctrl_timed.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_timed.sv
// Two-road traffic-light controller with timed green/yellow/all-red phases and XNOR LFSR sensors.
// Optional pedestrian request feature enabled by defining TRAFFIC_PED_REQ_EN.
module traffic_ctrl_timed #(
  parameter int unsigned       LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED_A     = 8'h5A,
  parameter logic [LFSR_W-1:0] SEED_B     = 8'hA5,
  parameter int unsigned       GREEN_MIN  = 4,
  parameter int unsigned       GREEN_MAX  = 12,
  parameter int unsigned       YELLOW_CYC = 2,
  parameter int unsigned       ALLRED_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_sense_en,
  input  logic       sense_a,
  input  logic       sense_b,
  input  logic       hold,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       RA,
  output logic       YA,
  output logic       GA,
  output logic       RB,
  output logic       YB,
  output logic       GB,
  output logic [2:0] state_o
);

  localparam int unsigned TMR_W = $clog2(GREEN_MAX + 1);

  typedef enum logic [2:0] {
    GRN_A = 3'd0,
    YEL_A = 3'd1,
    CLR_A = 3'd2,
    GRN_B = 3'd3,
    YEL_B = 3'd4,
    CLR_B = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic               w_exit;
  logic [TMR_W-1:0]   r_timer;
  logic [5:0]         r_lamps;
  logic [LFSR_W-1:0]  r_lfsr_a;
  logic [LFSR_W-1:0]  r_lfsr_b;
  logic               w_ta;
  logic               w_tb;
  logic               w_ped;

  // Lamp order: {RA, YA, GA, RB, YB, GB}
  function automatic logic [5:0] lamp_dec(input state_t s);
    case (s)
      GRN_A:   lamp_dec = 6'b001_100;
      YEL_A:   lamp_dec = 6'b010_100;
      GRN_B:   lamp_dec = 6'b100_001;
      YEL_B:   lamp_dec = 6'b100_010;
      default: lamp_dec = 6'b100_100;
    endcase
  endfunction

  assign w_ta = ext_sense_en ? sense_a : r_lfsr_a[0];
  assign w_tb = ext_sense_en ? sense_b : r_lfsr_b[0];

  // Free-running sensor LFSRs; they keep stepping while hold is asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
    end else begin
      r_lfsr_a <= {r_lfsr_a[LFSR_W-2:0], ~^(r_lfsr_a & LFSR_TAPS)};
      r_lfsr_b <= {r_lfsr_b[LFSR_W-2:0], ~^(r_lfsr_b & LFSR_TAPS)};
    end
  end

  // Phase exit condition and successor state
  always_comb begin
    w_exit = 1'b0;
    w_nxt  = GRN_A;
    case (r_state)
      GRN_A: begin
        w_exit = ((r_timer >= TMR_W'(GREEN_MIN - 1)) && (!w_ta || w_ped)) ||
                 (r_timer == TMR_W'(GREEN_MAX - 1));
        w_nxt  = YEL_A;
      end
      YEL_A: begin
        w_exit = (r_timer == TMR_W'(YELLOW_CYC - 1));
        w_nxt  = (ALLRED_CYC == 0) ? GRN_B : CLR_A;
      end
      CLR_A: begin
        w_exit = (r_timer == TMR_W'(ALLRED_CYC - 1));
        w_nxt  = GRN_B;
      end
      GRN_B: begin
        w_exit = ((r_timer >= TMR_W'(GREEN_MIN - 1)) && (!w_tb || w_ped)) ||
                 (r_timer == TMR_W'(GREEN_MAX - 1));
        w_nxt  = YEL_B;
      end
      YEL_B: begin
        w_exit = (r_timer == TMR_W'(YELLOW_CYC - 1));
        w_nxt  = (ALLRED_CYC == 0) ? GRN_A : CLR_B;
      end
      CLR_B: begin
        w_exit = (r_timer == TMR_W'(ALLRED_CYC - 1));
        w_nxt  = GRN_A;
      end
      default: begin
        w_exit = 1'b1;
        w_nxt  = GRN_A;
      end
    endcase
  end

  // State, phase timer and Moore lamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GRN_A;
      r_timer <= '0;
      r_lamps <= 6'b001_100;
    end else if (!hold) begin
      if (w_exit) begin
        r_state <= w_nxt;
        r_timer <= '0;
        r_lamps <= lamp_dec(w_nxt);
      end else if (r_timer != TMR_W'(GREEN_MAX)) begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

`ifdef TRAFFIC_PED_REQ_EN
  logic r_ped_pend;
  logic r_walk;
  logic w_enter_clr;

  if (ALLRED_CYC == 0) begin : g_ped_needs_allred
    $error("TRAFFIC_PED_REQ_EN requires ALLRED_CYC >= 1");
  end

  assign w_enter_clr = !hold && w_exit && ((w_nxt == CLR_A) || (w_nxt == CLR_B));
  assign w_ped       = r_ped_pend;
  assign walk        = r_walk;

  // A request landing on the clearing edge re-arms the pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
    end else begin
      if (ped_req) begin
        r_ped_pend <= 1'b1;
      end else if (w_enter_clr) begin
        r_ped_pend <= 1'b0;
      end
      if (!hold && w_exit) begin
        r_walk <= w_enter_clr && r_ped_pend;
      end
    end
  end
`else
  assign w_ped = 1'b0;
`endif

  assign {RA, YA, GA, RB, YB, GB} = r_lamps;
  assign state_o = r_state;

endmodule
